shift_add_mul: RTL and testbench
================================

SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, a request to begin a multiply, sampled on the rising edge of clk.
REQ-005 The block SHALL have port a, input, WIDTH, the unsigned multiplicand, sampled with start.
REQ-006 The block SHALL have port b, input, WIDTH, the unsigned multiplier, sampled with start.
REQ-007 The block SHALL have port busy, output, 1, which is high while an operation is in progress and start is ignored.
REQ-008 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-009 The block SHALL have port product, output, 2*WIDTH, the registered unsigned result a*b.

Function
REQ-010 The block SHALL implement the FSM states IDLE, RUN and DONE; busy SHALL equal (state != IDLE).
REQ-011 On a clock edge in IDLE with start=1, the block SHALL capture a and b into internal registers, clear the accumulator and step counter, and enter RUN.
REQ-012 start SHALL be ignored in RUN and DONE; operand changes on a and b SHALL have no effect after capture.
REQ-013 Each RUN edge SHALL perform exactly one shift-add iteration: if the multiplier LSB=1, the multiplicand is added into the upper WIDTH bits of the accumulator with a carry-out bit (WIDTH+1-bit sum); the {carry, accumulator, multiplier} register is then shifted right by 1, with no overflow possible.
REQ-014 RUN SHALL last exactly WIDTH edges, with the counter counting 0..WIDTH-1; on the WIDTH-th iteration edge the block SHALL load product with the final 2*WIDTH result and enter DONE.
REQ-015 Latency: for a start accepted at edge E0, product and done SHALL become valid after edge E0+WIDTH, and done SHALL fall after edge E0+WIDTH+1, when the FSM returns to IDLE.
REQ-016 Latency SHALL be fixed and data-independent, with no early termination for zero operands.
REQ-017 done SHALL be high for exactly one cycle per accepted start, and SHALL be high only in DONE.
REQ-018 product SHALL hold its value from DONE entry until the next DONE entry, and SHALL not change during RUN.
REQ-019 A start presented in the first IDLE cycle after DONE SHALL be accepted, giving back-to-back operations with a period of WIDTH+2 cycles.
REQ-020 Counter wrap: the counter SHALL not advance outside RUN and SHALL be reloaded to 0 at each accepted start.

Reset
REQ-021 Asserting rst SHALL immediately and asynchronously force the state to IDLE and busy=0, done=0, product=0, and clear all internal registers to 0.
REQ-022 A reset during RUN or DONE SHALL abort the operation without producing a done pulse; the first start after rst deasserts SHALL be accepted normally.
REQ-023 While rst=1, start SHALL be ignored.

Verification
REQ-024 With WIDTH=8, a=13 and b=11, start for 1 cycle -> busy high for 9 cycles, done pulses exactly 8 edges after the accepting edge, and product=0x008F.
REQ-025 With WIDTH=8, a=0xFF and b=0xFF -> product=0xFE01, exercising the carry-out path; a=0x00 and b=0xFF -> product=0x0000 with identical latency.
REQ-026 With the first op 13*11 accepted and start re-asserted at RUN cycles 2 and 5 with a=0xAA and b=0x55 -> those requests are ignored, product=0x008F, and exactly one done pulse occurs.
REQ-027 rst asserted asynchronously (mid-cycle) during RUN cycle 4 of 200*3 -> busy, done and product=0 immediately, and no done pulse follows; a new start with 7*6 then gives product=0x002A.
REQ-028 With start held high continuously using a=5 and b=9 -> an operation completes every 10 cycles, product=0x002D each time, and there is one done pulse per operation.

Source files
------------

// File: rtl/shift_add_mul.sv
// Sequential unsigned multiplier with one shift-add step per RUN cycle.
// The result is valid for one DONE cycle and then held until the next DONE.
module shift_add_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH:0]       sum;

  // Handshake: start is a request that is accepted on a rising edge only while
  // busy is low; a, b are sampled on that same edge and never again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
    end
  end

  // acc_q holds {partial product, remaining multiplier bits}; sum keeps the carry.
  always_comb begin
    sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          acc_d   = {{WIDTH{1'b0}}, b};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
        if (cnt_q == CW'(WIDTH - 1)) begin
          product_d = {sum, acc_q[WIDTH-1:1]};
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_shift_add_mul.sv
// Bench for shift_add_mul: expected products come from plain a*b and the
// cycle timing from the accept edge, kept in an expected queue.
module tb_shift_add_mul;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a, b;
  logic           busy, done;
  logic [2*W-1:0] product;
  logic [1:0]     state_o;

  int             checks = 0;
  int             errors = 0;
  logic [2*W-1:0] last_prod;
  logic [2*W-1:0] exp_q[$];

  shift_add_mul #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // idx i = the negedge following accept edge E0+i; done expected at idx W.
  task automatic observe(input logic [31:0] mask, input string name);
    logic [2*W-1:0] exp_p;
    logic [2*W-1:0] want;
    exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== (i <= W)) begin
        errors++;
        $display("FAIL %s busy idx %0d got %b exp %b", name, i, busy, (i <= W));
      end
      checks++;
      if (done !== (i == W)) begin
        errors++;
        $display("FAIL %s done idx %0d got %b exp %b", name, i, done, (i == W));
      end
      want = (i >= W) ? exp_p : last_prod;
      checks++;
      if (product !== want) begin
        errors++;
        $display("FAIL %s product idx %0d got %h exp %h", name, i, product, want);
      end
      start = mask[i];
      if (mask[i]) begin
        a = 8'hAA;
        b = 8'h55;
      end else begin
        a = W'($urandom);
        b = W'($urandom);
      end
    end
    start = 1'b0;
    last_prod = exp_p;
  endtask

  task automatic launch(input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [31:0] mask, input string name);
    @(negedge clk);
    start = 1'b1;
    a = aa;
    b = bb;
    exp_q.push_back({{W{1'b0}}, aa} * {{W{1'b0}}, bb});
    observe(mask, name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    a = 8'h12;
    b = 8'h34;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
        errors++;
        $display("FAIL reset_hold got busy=%b done=%b product=%h exp 0/0/0", busy, done, product);
      end
    end
    rst = 1'b0;
    start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_release busy got %b exp 0", busy);
      end
    end
    last_prod = '0;
  endtask

  task automatic test_basic();
    launch(8'd13, 8'd11, 32'h0, "basic_13x11");
    launch(8'd13, 8'd11, 32'h0000_0012, "ignore_start");
  endtask

  task automatic test_corners();
    launch(8'hFF, 8'hFF, 32'h0, "ff_x_ff");
    launch(8'h00, 8'hFF, 32'h0, "zero_x_ff");
    launch(8'hFF, 8'h01, 32'h0, "ff_x_1");
    launch(8'h01, 8'h80, 32'h0, "1_x_80");
    launch(8'h00, 8'h00, 32'h0, "zero_x_zero");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start = 1'b1;
    a = 8'd200;
    b = 8'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre busy got %b exp 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++;
      $display("FAIL abort_now got busy=%b done=%b product=%h exp 0/0/0", busy, done, product);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || product !== '0) begin
        errors++;
        $display("FAIL abort_after idx %0d got busy=%b done=%b product=%h exp 0/0/0",
                 i, busy, done, product);
      end
    end
    last_prod = '0;
    launch(8'd7, 8'd6, 32'h0, "after_abort_7x6");
  endtask

  task automatic test_back_to_back();
    int n_done;
    logic [2*W-1:0] want;
    n_done = 0;
    @(negedge clk);
    start = 1'b1;
    a = 8'd5;
    b = 8'd9;
    for (int i = 0; i < 4 * (W + 2); i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
      checks++;
      if (done !== ((i % (W + 2)) == W) || busy !== ((i % (W + 2)) != W + 1)) begin
        errors++;
        $display("FAIL b2b idx %0d got busy=%b done=%b", i, busy, done);
      end
      want = (i >= W) ? 16'h002D : last_prod;
      checks++;
      if (product !== want) begin
        errors++;
        $display("FAIL b2b product idx %0d got %h exp %h", i, product, want);
      end
    end
    start = 1'b0;
    checks++;
    if (n_done != 4) begin
      errors++;
      $display("FAIL b2b done_count got %0d exp 4", n_done);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b idle busy got %b exp 0", busy);
    end
    last_prod = 16'h002D;
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    for (int k = 0; k < 20; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (k % 7 == 3) ra = '0;
      launch(ra, rb, $urandom & 32'h0000_00FE, "random");
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    last_prod = '0;
    test_reset();
    test_basic();
    test_corners();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
